// File: rtl/pe_seq_pkg.sv
// Shared types and word-count arithmetic for the PE stream sequencer.
// Counts are computed in 32 bits and masked to the caller's counter width after each product.
package pe_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_READY,
    ST_RUN,
    ST_DONE
  } seq_state_t;

  function automatic int unsigned pack_ratio(input int unsigned wide, input int unsigned narrow);
    return wide / narrow;
  endfunction

  function automatic int unsigned cnt_mask(input int unsigned cnt_w);
    return (cnt_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cnt_w) - 32'd1);
  endfunction

  // Input row width: W = (F-1)*U + S
  function automatic int unsigned calc_w(input int unsigned s, input int unsigned f,
                                         input int unsigned u, input int unsigned cnt_w);
    int unsigned m;
    m = cnt_mask(cnt_w);
    return (((((f - 1) & m) * u) & m) + s) & m;
  endfunction

  function automatic int unsigned calc_n_if(input int unsigned n, input int unsigned w,
                                            input int unsigned q, input int unsigned cnt_w);
    int unsigned m;
    m = cnt_mask(cnt_w);
    return ((((n * w) & m) * q) & m);
  endfunction

  function automatic int unsigned calc_n_fl(input int unsigned p, input int unsigned q,
                                            input int unsigned s, input int unsigned pack,
                                            input int unsigned cnt_w);
    int unsigned m;
    int unsigned prod;
    m    = cnt_mask(cnt_w);
    prod = (((p * q) & m) * s) & m;
    return ((prod + pack - 1) / pack) & m;
  endfunction

  function automatic int unsigned calc_n_ps(input int unsigned p, input int unsigned n,
                                            input int unsigned f, input int unsigned pack,
                                            input int unsigned cnt_w);
    int unsigned m;
    int unsigned prod;
    m    = cnt_mask(cnt_w);
    prod = (((p * n) & m) * f) & m;
    return ((prod + pack - 1) / pack) & m;
  endfunction

endpackage

// File: rtl/pe_seq_load_channel.sv
// One buffer-to-FIFO load stream: read issue, one-entry staging register, push under back-pressure.
// Optional o_blocked output exists only with PE_STREAM_SEQ_STALL_CNT_EN.
module pe_seq_load_channel #(
  parameter int unsigned DW         = 16,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_run,
  input  logic [CNT_WIDTH-1:0]  i_n,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [DW-1:0]         i_rd_data,
  output logic                  o_push,
  output logic [DW-1:0]         o_data,
  input  logic                  i_full,
  output logic                  o_complete
`ifdef PE_STREAM_SEQ_STALL_CNT_EN
  , output logic                o_blocked
`endif
);

  logic [CNT_WIDTH-1:0] r_req;
  logic [CNT_WIDTH-1:0] r_pushed;
  logic                 r_stg_valid;
  logic                 r_fresh;
  logic [DW-1:0]        r_stg_data;
  logic [DW-1:0]        w_stg_data;
  logic                 w_push;
  logic                 w_rd;

  // Freshly returned read data is pushed straight from the buffer port; it is also
  // captured so it survives a full FIFO.
  assign w_stg_data = r_fresh ? i_rd_data : r_stg_data;
  assign w_push     = i_run & r_stg_valid & ~i_full;
  assign w_rd       = i_run & (r_req < i_n) & (~r_stg_valid | w_push);

  assign o_rd_en    = w_rd;
  assign o_rd_addr  = ADDR_WIDTH'(r_req);
  assign o_push     = w_push;
  assign o_data     = w_stg_data;
  assign o_complete = (r_pushed == i_n);
`ifdef PE_STREAM_SEQ_STALL_CNT_EN
  assign o_blocked  = r_stg_valid & i_full;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req       <= '0;
      r_pushed    <= '0;
      r_stg_valid <= 1'b0;
      r_fresh     <= 1'b0;
      r_stg_data  <= '0;
    end else if (i_start) begin
      r_req       <= '0;
      r_pushed    <= '0;
      r_stg_valid <= 1'b0;
      r_fresh     <= 1'b0;
      r_stg_data  <= '0;
    end else begin
      r_fresh <= w_rd;
      if (w_rd)
        r_req <= r_req + 1'b1;
      if (w_push)
        r_pushed <= r_pushed + 1'b1;
      if (w_rd)
        r_stg_valid <= 1'b1;
      else if (w_push)
        r_stg_valid <= 1'b0;
      if (r_fresh)
        r_stg_data <= i_rd_data;
    end
  end

endmodule

// File: rtl/pe_stream_sequencer.sv
// Layer-level sequencer feeding PE_wrapper FIFOs from read buffers and draining opsum to a write buffer.
// Optional stall counters enabled by PE_STREAM_SEQ_STALL_CNT_EN.
module pe_stream_sequencer
  import pe_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = 16,
  parameter int unsigned DATA_WIDTH_IFMAP  = 16,
  parameter int unsigned DATA_WIDTH_FILTER = 64,
  parameter int unsigned DATA_WIDTH_PSUM   = 64,
  parameter int unsigned S_WIDTH           = 5,
  parameter int unsigned F_WIDTH           = 6,
  parameter int unsigned U_WIDTH           = 3,
  parameter int unsigned n_WIDTH           = 3,
  parameter int unsigned p_WIDTH           = 5,
  parameter int unsigned q_WIDTH           = 3,
  parameter int unsigned ADDR_WIDTH        = 12,
  parameter int unsigned CNT_WIDTH         = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         configure,
  input  logic [S_WIDTH-1:0]           S,
  input  logic [F_WIDTH-1:0]           F,
  input  logic [U_WIDTH-1:0]           U,
  input  logic [n_WIDTH-1:0]           n,
  input  logic [p_WIDTH-1:0]           p,
  input  logic [q_WIDTH-1:0]           q,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         if_rd_en,
  output logic [ADDR_WIDTH-1:0]        if_rd_addr,
  input  logic [DATA_WIDTH_IFMAP-1:0]  if_rd_data,
  output logic                         fl_rd_en,
  output logic [ADDR_WIDTH-1:0]        fl_rd_addr,
  input  logic [DATA_WIDTH_FILTER-1:0] fl_rd_data,
  output logic                         ps_rd_en,
  output logic [ADDR_WIDTH-1:0]        ps_rd_addr,
  input  logic [DATA_WIDTH_PSUM-1:0]   ps_rd_data,
  output logic                         push_ifmap,
  output logic [DATA_WIDTH_IFMAP-1:0]  ifmap,
  input  logic                         ifmap_fifo_full,
  output logic                         push_filter,
  output logic [DATA_WIDTH_FILTER-1:0] filter,
  input  logic                         filter_fifo_full,
  output logic                         push_ipsum,
  output logic [DATA_WIDTH_PSUM-1:0]   ipsum,
  input  logic                         ipsum_fifo_full,
  output logic                         pop_opsum,
  input  logic [DATA_WIDTH_PSUM-1:0]   opsum,
  input  logic                         opsum_fifo_empty,
  output logic                         op_wr_en,
  output logic [ADDR_WIDTH-1:0]        op_wr_addr,
  output logic [DATA_WIDTH_PSUM-1:0]   op_wr_data
`ifdef PE_STREAM_SEQ_STALL_CNT_EN
  , output logic [CNT_WIDTH-1:0]       stall_if
  , output logic [CNT_WIDTH-1:0]       stall_fl
  , output logic [CNT_WIDTH-1:0]       stall_ps
  , output logic [CNT_WIDTH-1:0]       stall_op
`endif
);

  localparam int unsigned PACK_F = pack_ratio(DATA_WIDTH_FILTER, DATA_WIDTH);
  localparam int unsigned PACK_P = pack_ratio(DATA_WIDTH_PSUM, DATA_WIDTH);

  seq_state_t           r_state;
  logic                 r_busy;
  logic                 r_done;
  logic [S_WIDTH-1:0]   r_S;
  logic [F_WIDTH-1:0]   r_F;
  logic [U_WIDTH-1:0]   r_U;
  logic [n_WIDTH-1:0]   r_n;
  logic [p_WIDTH-1:0]   r_p;
  logic [q_WIDTH-1:0]   r_q;
  logic [CNT_WIDTH-1:0] r_n_if;
  logic [CNT_WIDTH-1:0] r_n_fl;
  logic [CNT_WIDTH-1:0] r_n_ps;
  logic [CNT_WIDTH-1:0] r_popped;

  logic w_run;
  logic w_start;
  logic w_pop;
  logic w_if_cmpl;
  logic w_fl_cmpl;
  logic w_ps_cmpl;
  logic w_all_cmpl;

  assign w_run      = (r_state == ST_RUN);
  assign w_start    = (r_state == ST_READY) & start & ~configure;
  assign w_pop      = w_run & ~opsum_fifo_empty & (r_popped < r_n_ps);
  assign w_all_cmpl = w_if_cmpl & w_fl_cmpl & w_ps_cmpl & (r_popped == r_n_ps);

  assign busy       = r_busy;
  assign done       = r_done;
  assign pop_opsum  = w_pop;
  assign op_wr_en   = w_pop;
  assign op_wr_addr = w_pop ? ADDR_WIDTH'(r_popped) : '0;
  assign op_wr_data = w_pop ? opsum : '0;

`ifdef PE_STREAM_SEQ_STALL_CNT_EN
  logic w_if_blk;
  logic w_fl_blk;
  logic w_ps_blk;
`endif

  pe_seq_load_channel #(.DW(DATA_WIDTH_IFMAP), .ADDR_WIDTH(ADDR_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_if_ch (
    .clk        (clk),
    .rst        (reset),
    .i_start    (w_start),
    .i_run      (w_run),
    .i_n        (r_n_if),
    .o_rd_en    (if_rd_en),
    .o_rd_addr  (if_rd_addr),
    .i_rd_data  (if_rd_data),
    .o_push     (push_ifmap),
    .o_data     (ifmap),
    .i_full     (ifmap_fifo_full),
    .o_complete (w_if_cmpl)
`ifdef PE_STREAM_SEQ_STALL_CNT_EN
    , .o_blocked (w_if_blk)
`endif
  );

  pe_seq_load_channel #(.DW(DATA_WIDTH_FILTER), .ADDR_WIDTH(ADDR_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_fl_ch (
    .clk        (clk),
    .rst        (reset),
    .i_start    (w_start),
    .i_run      (w_run),
    .i_n        (r_n_fl),
    .o_rd_en    (fl_rd_en),
    .o_rd_addr  (fl_rd_addr),
    .i_rd_data  (fl_rd_data),
    .o_push     (push_filter),
    .o_data     (filter),
    .i_full     (filter_fifo_full),
    .o_complete (w_fl_cmpl)
`ifdef PE_STREAM_SEQ_STALL_CNT_EN
    , .o_blocked (w_fl_blk)
`endif
  );

  pe_seq_load_channel #(.DW(DATA_WIDTH_PSUM), .ADDR_WIDTH(ADDR_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_ps_ch (
    .clk        (clk),
    .rst        (reset),
    .i_start    (w_start),
    .i_run      (w_run),
    .i_n        (r_n_ps),
    .o_rd_en    (ps_rd_en),
    .o_rd_addr  (ps_rd_addr),
    .i_rd_data  (ps_rd_data),
    .o_push     (push_ipsum),
    .o_data     (ipsum),
    .i_full     (ipsum_fifo_full),
    .o_complete (w_ps_cmpl)
`ifdef PE_STREAM_SEQ_STALL_CNT_EN
    , .o_blocked (w_ps_blk)
`endif
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_S      <= '0;
      r_F      <= '0;
      r_U      <= '0;
      r_n      <= '0;
      r_p      <= '0;
      r_q      <= '0;
      r_n_if   <= '0;
      r_n_fl   <= '0;
      r_n_ps   <= '0;
      r_popped <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (configure) begin
            {r_S, r_F, r_U, r_n, r_p, r_q} <= {S, F, U, n, p, q};
            r_state <= ST_CALC;
            r_busy  <= 1'b1;
          end
        end
        ST_CALC: begin
          r_n_if  <= CNT_WIDTH'(calc_n_if(32'(r_n),
                                          calc_w(32'(r_S), 32'(r_F), 32'(r_U), CNT_WIDTH),
                                          32'(r_q), CNT_WIDTH));
          r_n_fl  <= CNT_WIDTH'(calc_n_fl(32'(r_p), 32'(r_q), 32'(r_S), PACK_F, CNT_WIDTH));
          r_n_ps  <= CNT_WIDTH'(calc_n_ps(32'(r_p), 32'(r_n), 32'(r_F), PACK_P, CNT_WIDTH));
          r_state <= ST_READY;
          r_busy  <= 1'b0;
        end
        ST_READY: begin
          if (configure) begin
            {r_S, r_F, r_U, r_n, r_p, r_q} <= {S, F, U, n, p, q};
            r_state <= ST_CALC;
            r_busy  <= 1'b1;
          end else if (start) begin
            r_popped <= '0;
            r_state  <= ST_RUN;
            r_busy   <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_pop)
            r_popped <= r_popped + 1'b1;
          if (w_all_cmpl) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PE_STREAM_SEQ_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] r_stall_if;
  logic [CNT_WIDTH-1:0] r_stall_fl;
  logic [CNT_WIDTH-1:0] r_stall_ps;
  logic [CNT_WIDTH-1:0] r_stall_op;
  logic                 w_op_blk;

  assign w_op_blk = opsum_fifo_empty & (r_popped < r_n_ps);
  assign stall_if = r_stall_if;
  assign stall_fl = r_stall_fl;
  assign stall_ps = r_stall_ps;
  assign stall_op = r_stall_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_if <= '0;
      r_stall_fl <= '0;
      r_stall_ps <= '0;
      r_stall_op <= '0;
    end else if (w_start) begin
      r_stall_if <= '0;
      r_stall_fl <= '0;
      r_stall_ps <= '0;
      r_stall_op <= '0;
    end else if (w_run) begin
      if (w_if_blk && !(&r_stall_if)) r_stall_if <= r_stall_if + 1'b1;
      if (w_fl_blk && !(&r_stall_fl)) r_stall_fl <= r_stall_fl + 1'b1;
      if (w_ps_blk && !(&r_stall_ps)) r_stall_ps <= r_stall_ps + 1'b1;
      if (w_op_blk && !(&r_stall_op)) r_stall_op <= r_stall_op + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_stream_sequencer.sv
// Directed self-checking bench for pe_stream_sequencer; stall counters checked when
// PE_STREAM_SEQ_STALL_CNT_EN is defined.
module tb_pe_stream_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        configure;
  logic [4:0]  S;
  logic [5:0]  F;
  logic [2:0]  U;
  logic [2:0]  n;
  logic [4:0]  p;
  logic [2:0]  q;
  logic        start;
  logic        busy;
  logic        done;
  logic        if_rd_en, fl_rd_en, ps_rd_en;
  logic [11:0] if_rd_addr, fl_rd_addr, ps_rd_addr;
  logic [15:0] if_rd_data;
  logic [63:0] fl_rd_data, ps_rd_data;
  logic        push_ifmap, push_filter, push_ipsum;
  logic [15:0] ifmap;
  logic [63:0] filter, ipsum;
  logic        ifmap_fifo_full, filter_fifo_full, ipsum_fifo_full;
  logic        pop_opsum;
  logic [63:0] opsum;
  logic        opsum_fifo_empty;
  logic        op_wr_en;
  logic [11:0] op_wr_addr;
  logic [63:0] op_wr_data;
`ifdef PE_STREAM_SEQ_STALL_CNT_EN
  logic [15:0] stall_if, stall_fl, stall_ps, stall_op;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned cnt_if, cnt_fl, cnt_ps, cnt_op, n_done;
  int unsigned exp_if, exp_fl, exp_ps, exp_op;
  logic        toggle_mode;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] if_word(input int unsigned a);
    return 16'(a * 5 + 7);
  endfunction
  function automatic logic [63:0] fl_word(input int unsigned a);
    return {16'hF11E, 16'(a), 16'h5A5A, 16'(a + 100)};
  endfunction
  function automatic logic [63:0] ps_word(input int unsigned a);
    return {16'hB0B0, 16'(a * 3), 16'h1234, 16'(a)};
  endfunction
  function automatic logic [63:0] op_word(input int unsigned a);
    return {32'hC0FFEE00, 32'(a)};
  endfunction

  always @(posedge clk) begin
    if (if_rd_en) if_rd_data <= if_word(32'(if_rd_addr));
    if (fl_rd_en) fl_rd_data <= fl_word(32'(fl_rd_addr));
    if (ps_rd_en) ps_rd_data <= ps_word(32'(ps_rd_addr));
  end

  assign opsum            = op_word(cnt_op);
  assign opsum_fifo_empty = toggle_mode & cyc[0];

  pe_stream_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .configure        (configure),
    .S                (S),
    .F                (F),
    .U                (U),
    .n                (n),
    .p                (p),
    .q                (q),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .if_rd_en         (if_rd_en),
    .if_rd_addr       (if_rd_addr),
    .if_rd_data       (if_rd_data),
    .fl_rd_en         (fl_rd_en),
    .fl_rd_addr       (fl_rd_addr),
    .fl_rd_data       (fl_rd_data),
    .ps_rd_en         (ps_rd_en),
    .ps_rd_addr       (ps_rd_addr),
    .ps_rd_data       (ps_rd_data),
    .push_ifmap       (push_ifmap),
    .ifmap            (ifmap),
    .ifmap_fifo_full  (ifmap_fifo_full),
    .push_filter      (push_filter),
    .filter           (filter),
    .filter_fifo_full (filter_fifo_full),
    .push_ipsum       (push_ipsum),
    .ipsum            (ipsum),
    .ipsum_fifo_full  (ipsum_fifo_full),
    .pop_opsum        (pop_opsum),
    .opsum            (opsum),
    .opsum_fifo_empty (opsum_fifo_empty),
    .op_wr_en         (op_wr_en),
    .op_wr_addr       (op_wr_addr),
    .op_wr_data       (op_wr_data)
`ifdef PE_STREAM_SEQ_STALL_CNT_EN
    , .stall_if       (stall_if)
    , .stall_fl       (stall_fl)
    , .stall_ps       (stall_ps)
    , .stall_op       (stall_op)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    if (push_ifmap) begin
      check("ifmap_data", 64'(ifmap), 64'(if_word(cnt_if)));
      cnt_if++;
    end
    if (push_filter) begin
      check("filter_data", filter, fl_word(cnt_fl));
      cnt_fl++;
    end
    if (push_ipsum) begin
      check("ipsum_data", ipsum, ps_word(cnt_ps));
      cnt_ps++;
    end
    if (filter_fifo_full) begin
      check("fl_push_rd_low", 64'({push_filter, fl_rd_en}), 64'd0);
      check("fl_data_held", filter, fl_word(cnt_fl));
    end
    if (pop_opsum) begin
      check("pop_not_empty", 64'(opsum_fifo_empty), 64'd0);
      check("pop_wr_en", 64'(op_wr_en), 64'd1);
    end
    if (op_wr_en) begin
      check("op_bound", 64'(cnt_op < exp_op), 64'd1);
      check("op_addr", 64'(op_wr_addr), 64'(cnt_op));
      check("op_data", op_wr_data, op_word(cnt_op));
      cnt_op++;
    end
    if (done) n_done++;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    cnt_if = 0; cnt_fl = 0; cnt_ps = 0; cnt_op = 0; n_done = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 64'({busy, done, if_rd_en, fl_rd_en, ps_rd_en, push_ifmap, push_filter,
                    push_ipsum, pop_opsum, op_wr_en}), 64'd0);
    check({tag, "_addr"}, 64'({if_rd_addr, fl_rd_addr, ps_rd_addr, op_wr_addr}), 64'd0);
    check({tag, "_data"}, ifmap | filter | ipsum | op_wr_data, 64'd0);
  endtask

  task automatic set_shape(input int unsigned s_v, f_v, u_v, n_v, p_v, q_v,
                           input int unsigned e_if, e_fl, e_ps);
    S = 5'(s_v); F = 6'(f_v); U = 3'(u_v); n = 3'(n_v); p = 5'(p_v); q = 3'(q_v);
    exp_if = e_if; exp_fl = e_fl; exp_ps = e_ps; exp_op = e_ps;
    configure = 1'b1;
    tick();
    configure = 1'b0;
    check("calc_busy", 64'(busy), 64'd1);
    tick();
    check("ready_not_busy", 64'(busy), 64'd0);
  endtask

  task automatic run_layer(input bit fl_stall);
    int unsigned guard;
    int unsigned stall_left;
    bit          stalled;
    guard = 0; stall_left = 0; stalled = 0;
    clear_counts();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("run_busy", 64'(busy), 64'd1);
    while (n_done == 0 && guard < 3000) begin
      if (fl_stall && !stalled && cnt_fl >= 10) begin
        filter_fifo_full = 1'b1;
        stall_left = 20;
        stalled = 1'b1;
      end
      tick();
      guard++;
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) filter_fifo_full = 1'b0;
      end
    end
    filter_fifo_full = 1'b0;
    tick();
    tick();
    check("done_pulses", 64'(n_done), 64'd1);
    check("busy_after", 64'(busy), 64'd0);
    check("total_if", 64'(cnt_if), 64'(exp_if));
    check("total_fl", 64'(cnt_fl), 64'(exp_fl));
    check("total_ps", 64'(cnt_ps), 64'(exp_ps));
    check("total_op", 64'(cnt_op), 64'(exp_op));
  endtask

  initial begin
    int unsigned guard;
    reset = 1'b1; configure = 1'b0; start = 1'b0;
    S = '0; F = '0; U = '0; n = '0; p = '0; q = '0;
    ifmap_fifo_full = 1'b0; filter_fifo_full = 1'b0; ipsum_fifo_full = 1'b0;
    toggle_mode = 1'b0;
    exp_if = 0; exp_fl = 0; exp_ps = 0; exp_op = 0;
    clear_counts();
    tick();
    tick();
    check_all_zero("reset_outputs");
    reset = 1'b0;
    tick();

    // start in IDLE must be ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    check("idle_start_busy", 64'(busy), 64'd0);
    tick();
    check("idle_start_noread", 64'({busy, if_rd_en}), 64'd0);

    // configure wins over simultaneous start in READY
    set_shape(3, 13, 1, 4, 16, 3, 180, 36, 208);
    configure = 1'b1; start = 1'b1;
    tick();
    configure = 1'b0; start = 1'b0;
    check("cfg_start_calc", 64'(busy), 64'd1);
    tick();
    check("cfg_start_ready", 64'(busy), 64'd0);
    tick();
    check("cfg_start_norun", 64'({if_rd_en, 32'(cnt_if)}), 64'd0);

    run_layer(1'b0);

    set_shape(3, 13, 1, 4, 16, 3, 180, 36, 208);
    run_layer(1'b1);
`ifdef PE_STREAM_SEQ_STALL_CNT_EN
    check("stall_fl", 64'(stall_fl), 64'd20);
    check("stall_others", 64'({stall_if, stall_ps, stall_op}), 64'd0);
`endif

    toggle_mode = 1'b1;
    set_shape(3, 13, 1, 4, 16, 3, 180, 36, 208);
    run_layer(1'b0);
    toggle_mode = 1'b0;

    // abort by reset after 50 ifmap pushes
    set_shape(3, 13, 1, 4, 16, 3, 180, 36, 208);
    clear_counts();
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (cnt_if < 50 && guard < 1000) begin
      tick();
      guard++;
    end
    check("abort_point", 64'(cnt_if), 64'd50);
    reset = 1'b1;
    #1;
    check_all_zero("abort_outputs");
    tick();
    tick();
    tick();
    check("abort_no_done", 64'(n_done), 64'd0);
    reset = 1'b0;
    tick();
    set_shape(3, 13, 1, 4, 16, 3, 180, 36, 208);
    run_layer(1'b0);

    set_shape(1, 1, 1, 1, 1, 1, 1, 1, 1);
    run_layer(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_stream_sequencer.md
Name: pe_stream_sequencer

Overview:
- Synthesisable layer-level sequencer in front of PE_wrapper.
- Latches a layer shape (S,F,U,n,p,q), derives per-stream word counts, and streams ifmap/filter/ipsum words from three read-only buffer memories into the PE FIFOs under full back-pressure.
- Drains opsum into a write buffer under empty handshake.
- Replaces fixed-count bench drivers with a parametrised, hardware-side engine for any layer shape within the parameter limits.

Parameters:
- DATA_WIDTH, 16, PE element width.
- DATA_WIDTH_IFMAP, 16, ifmap word width.
- DATA_WIDTH_FILTER, 64, filter word width (PACK_F = DATA_WIDTH_FILTER/DATA_WIDTH).
- DATA_WIDTH_PSUM, 64, psum word width (PACK_P = DATA_WIDTH_PSUM/DATA_WIDTH).
- S_WIDTH, 5; F_WIDTH, 6; U_WIDTH, 3; n_WIDTH, 3; p_WIDTH, 5; q_WIDTH, 3: shape field widths.
- ADDR_WIDTH, 12, buffer address width for every memory port.
- CNT_WIDTH, 16, word counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- configure  in  1  latch shape fields (honoured in IDLE/READY only).
- S,F,U,n,p,q  in  field widths  layer shape.
- start  in  1  begin streaming (honoured in READY only).
- busy  out  1  high in CALC/RUN.
- done  out  1  one-cycle pulse when layer complete.
- if_rd_en / if_rd_addr / if_rd_data  out/out/in  1/ADDR_WIDTH/DATA_WIDTH_IFMAP  ifmap buffer read, 1-cycle latency.
- fl_rd_en / fl_rd_addr / fl_rd_data  same form, DATA_WIDTH_FILTER data  filter buffer read.
- ps_rd_en / ps_rd_addr / ps_rd_data  same form, DATA_WIDTH_PSUM data  ipsum buffer read.
- push_ifmap, ifmap, ifmap_fifo_full  out/out/in  1/DATA_WIDTH_IFMAP/1  PE ifmap FIFO.
- push_filter, filter, filter_fifo_full  out/out/in  1/DATA_WIDTH_FILTER/1  PE filter FIFO.
- push_ipsum, ipsum, ipsum_fifo_full  out/out/in  1/DATA_WIDTH_PSUM/1  PE ipsum FIFO.
- pop_opsum, opsum, opsum_fifo_empty  out/in/in  1/DATA_WIDTH_PSUM/1  PE opsum FIFO.
- op_wr_en / op_wr_addr / op_wr_data  out/out/out  1/ADDR_WIDTH/DATA_WIDTH_PSUM  opsum write buffer.

Behaviour:
- Reset: every output 0, state IDLE, all counters and staging registers cleared.
- Reset asserted mid-RUN aborts immediately: no further push/pop/write, no done pulse.
- States:
  - IDLE --configure--> CALC.
  - CALC (1 cycle): compute W = (F-1)*U + S; N_IF = n*W*q; N_FL = ceil(p*q*S / PACK_F); N_PS = ceil(p*n*F / PACK_P); N_OP = N_PS. Then go to READY.
  - READY --configure--> CALC (re-latch; configure wins over a simultaneous start). READY --start--> RUN.
  - RUN --all four channels complete--> DONE.
  - DONE (1 cycle, done=1) --> IDLE.
- configure and start in any other state are ignored.
- Products are computed at CNT_WIDTH and truncated; shape legality is the caller's responsibility.
- Load channel (x3, independent):
  - One-entry staging register (valid flag).
  - Read issued when words_requested < N and (staging empty, or staging being pushed this cycle).
  - Address = words_requested, starting at 0.
  - Read data lands in staging the next cycle.
  - Push asserted for exactly one cycle with data when staging is valid and fifo_full = 0.
  - When fifo_full = 1, push stays low, staging and data are held, and no new read is issued.
  - Sustained rate is 1 word/cycle when not full.
  - Channel is complete when pushed == N; N = 0 means complete on entering RUN.
- Drain channel:
  - pop_opsum = 1 when opsum_fifo_empty = 0 and popped < N_OP.
  - opsum is sampled in the same cycle as pop and written the same cycle: op_wr_en = 1, op_wr_addr = popped, op_wr_data = opsum.
  - At most one pop per cycle; never pops when empty; never pops beyond N_OP.
- Simultaneous push on all three channels plus a pop in one cycle is legal.
- busy = (state == CALC or state == RUN).

Optional Feature:
- Macro PE_STREAM_SEQ_STALL_CNT_EN.
- Defined:
  - Adds outputs stall_if, stall_fl, stall_ps, stall_op, each CNT_WIDTH wide.
  - Each counts RUN cycles in which that channel has work pending but is blocked (staging valid and full = 1 for loads; empty = 1 with popped < N_OP for drain).
  - Cleared on start, saturating, held after done.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- pe_seq_pkg holds:
  - state enum (IDLE, CALC, READY, RUN, DONE);
  - PACK_F/PACK_P derivation;
  - the word-count function (W, N_IF, N_FL, N_PS).
- Sub-module pe_seq_load_channel (parametrised by data width): counter, read issue, staging register, push logic. Instantiated three times.
- Drain logic and FSM are inline in the top module.

Test Plan:
- S=3,F=13,U=1,n=4,p=16,q=3, FIFOs never full, opsum supplied on demand -> 180 ifmap, 36 filter, 208 ipsum pushes; 208 opsum writes to addr 0..207; single done pulse; busy low afterwards.
- Same layer with filter_fifo_full held high for 20 cycles mid-stream -> filter push low and data held, no filter read issued; other channels continue; totals unchanged; stall_fl = 20 with the macro defined.
- opsum_fifo_empty toggles every cycle -> pop only on non-empty cycles; op_wr_addr strictly sequential; exactly 208 writes, no pop past N_OP.
- configure and start in the same cycle in READY -> re-enter CALC, no RUN; start in IDLE -> ignored, busy stays 0.
- reset asserted mid-RUN after 50 ifmap pushes -> all outputs 0 the same cycle, state IDLE, no done; a following full run gives correct counts from addr 0.
- p=1,q=1,S=1,n=1,F=1 -> N_FL = N_PS = 1 (ceil), N_IF = 1; done after all channels complete.
